fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of the 16x16 FIFO among
//  NREQ producers. Grants one producer at a time for a burst of up to BURST
//  words, throttles on fifo_full and rotates priority after every burst.
//  Sits between the producer blocks and the FIFO's write/fifo_in/full/half pins.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  DW    16  data width, equal to the FIFO word width
//  BURST 4   maximum words per grant (1..16)
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  req        in   NREQ     req[i]=1: producer i has a valid word on din[i]
//  din        in   NREQ*DW  producer words, packed; din[i*DW +: DW]
//  fifo_full  in   1        FIFO full flag
//  fifo_half  in   1        FIFO half flag
//  gnt        out  NREQ     one-hot registered grant (all zero when idle)
//  ack        out  NREQ     ack[i]=1: word on din[i] is consumed at this edge
//  write      out  1        FIFO write strobe
//  fifo_in    out  DW       FIFO write data
// BEHAVIOUR
//  Reset (reset=0, any time, async):
//   - state=IDLE, gnt=0, burst count=0, last pointer=NREQ-1, so producer 0 wins first.
//   - Combinationally write=0, ack=0, fifo_in=0.
//   - An in-flight burst is abandoned; no partial write is issued.
//  States: IDLE, GRANT.
//  IDLE:
//   - If req!=0, search from (last+1) mod NREQ upward with wrap; first set bit is g.
//   - Next edge: gnt=onehot(g), last=g, cnt=0, state=GRANT.
//   - Burst limit is latched at that edge: lim = fifo_half ? 1 : BURST.
//   - If req==0, stay in IDLE.
//  GRANT (combinational accept = req[g] & ~fifo_full):
//   - write=accept; ack[g]=accept; all other ack=0.
//   - fifo_in=din[g] while write=1, else 0.
//   - On accept: cnt=cnt+1 (4-bit, never wraps because lim<=16).
//   - Exit to IDLE, with gnt=0 at the next edge, when either:
//       accept and cnt==lim-1 (burst done), or
//       req[g]=0 (producer released early, no write that cycle).
//   - fifo_full=1 with req[g]=1: stall. Hold grant and cnt; no write, no ack.
//     No timeout.
//  Timing:
//   - Grant latency: request seen in IDLE -> gnt one edge later -> first write
//     in that same cycle if FIFO not full.
//   - Every burst is followed by one IDLE cycle, so max throughput is lim/(lim+1).
//  Producer rule: din[i] is held stable while req[i]=1 and ack[i]=0.
//   - Dropping req[i] without ack is legal; the word is not written.
//  Simultaneous events:
//   - Requests arriving during GRANT wait for the next IDLE arbitration.
//   - Mid-burst fifo_half changes do not alter lim.
//   - fifo_full is obeyed in the same cycle, so the FIFO is never written when full.
//  Invariants:
//   - gnt is at most one-hot.
//   - write==|ack.
//   - ack is a subset of gnt.
// TESTING
//  1. Reset, then req=4'b0001 held, 6 words, FIFO empty
//     -> gnt=0001 from cycle 1; 4 writes; 1 IDLE cycle; regrant; 2 more writes.
//  2. req=4'b1111 continuously, BURST=4
//     -> grant order 0,1,2,3,0; each burst exactly 4 writes; fifo_in matches din of grantee.
//  3. Grant to producer 2; fifo_full=1 for 3 cycles mid-burst
//     -> write=0 and ack=0 for 3 cycles; gnt stays 0100; burst resumes at same count.
//  4. fifo_half=1 at arbitration with req=4'b0011
//     -> 1-word bursts alternating 0,1; write pattern 1,0,1,0.
//  5. Producer 1 drops req after 2 words -> IDLE next edge; next grant goes to producer 2 or 3 if requesting.
//  6. Assert reset mid-burst (cnt=2) -> gnt/write/ack 0 immediately; after release, producer 0 is granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Grants bursts of up to BURST words, throttles on fifo_full and rotates priority per burst.
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    input  logic               fifo_full,
    input  logic               fifo_half,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               write,
    output logic [DW-1:0]      fifo_in
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                     state;
    logic   [IW-1:0]            last;
    logic   [3:0]               cnt;
    logic   [4:0]               lim;
    logic   [IW-1:0]            pick;
    logic                       pick_vld;
    logic   [IW:0]              scan;
    logic                       req_g;
    logic                       accept;
    logic                       burst_done;
    logic   [NREQ-1:0][DW-1:0]  lane_data;

    // Rotating search starting just after the last grantee; one extra bit
    // on scan lets the wrap be a single conditional subtract.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = {1'b0, last} + (IW+1)'(k);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!pick_vld && req[scan[IW-1:0]]) begin
                pick     = scan[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Per-producer slice: ack only the granted producer, and only when the
    // FIFO can take the word; data is masked so the OR-merge below is a mux.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign ack[i]       = gnt[i] & req[i] & ~fifo_full;
        assign lane_data[i] = ack[i] ? din[i*DW +: DW] : '0;
    end

    always_comb begin
        fifo_in = '0;
        for (int i = 0; i < NREQ; i++)
            fifo_in = fifo_in | lane_data[i];
    end

    assign write      = |ack;
    assign req_g      = |(req & gnt);
    assign accept     = (state == GRANT) && req_g && !fifo_full;
    assign burst_done = ({1'b0, cnt} == (lim - 5'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IW'(NREQ-1);
            cnt   <= '0;
            lim   <= 5'(BURST);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= GRANT;
                        gnt   <= NREQ'(1) << pick;
                        last  <= pick;
                        cnt   <= '0;
                        // Limit is frozen for the whole burst.
                        lim   <= fifo_half ? 5'd1 : 5'(BURST);
                    end
                end
                GRANT: begin
                    if (!req_g) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt + 4'd1;
                        if (burst_done) begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector tables plus a write-data scoreboard.
module tb_fifo_write_arbiter;
    localparam int NREQ = 4, DW = 16, BURST = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] din = '0;
    logic               fifo_full = 1'b0;
    logic               fifo_half = 1'b0;
    logic [NREQ-1:0]    gnt, ack;
    logic               write;
    logic [DW-1:0]      fifo_in;

    fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clock(clock), .reset(reset), .req(req), .din(din),
        .fifo_full(fifo_full), .fifo_half(fifo_half),
        .gnt(gnt), .ack(ack), .write(write), .fifo_in(fifo_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       half;
        logic [3:0] gnt;
        logic       wr;
        logic [3:0] ack;
    } vec_t;

    vec_t          vq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] din_cur[NREQ];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic f, input logic h,
                       input logic [3:0] g, input logic w, input logic [3:0] a);
        vec_t v;
        v.req = r; v.full = f; v.half = h; v.gnt = g; v.wr = w; v.ack = a;
        vq.push_back(v);
    endtask

    task automatic drive_din();
        for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = din_cur[i];
    endtask

    // Each row: inputs applied just after an edge, outputs checked 1 ns later.
    task automatic run(input string nm);
        foreach (vq[n]) begin
            @(posedge clock); #1;
            req = vq[n].req; fifo_full = vq[n].full; fifo_half = vq[n].half;
            drive_din();
            #1;
            chk($sformatf("%s[%0d].gnt", nm, n),   32'(gnt),   32'(vq[n].gnt));
            chk($sformatf("%s[%0d].write", nm, n), 32'(write), 32'(vq[n].wr));
            chk($sformatf("%s[%0d].ack", nm, n),   32'(ack),   32'(vq[n].ack));
            if (vq[n].wr)
                for (int i = 0; i < NREQ; i++)
                    if (vq[n].ack[i]) begin
                        sb.push_back(din_cur[i]);
                        din_cur[i] = din_cur[i] + 16'd1;
                    end
        end
        vq.delete();
    endtask

    task automatic do_reset(input string nm);
        @(posedge clock); #1;
        reset = 1'b0; req = '0; fifo_full = 1'b0; fifo_half = 1'b0;
        #1;
        chk({nm, ".rst_gnt"},     32'(gnt),     32'd0);
        chk({nm, ".rst_write"},   32'(write),   32'd0);
        chk({nm, ".rst_ack"},     32'(ack),     32'd0);
        chk({nm, ".rst_fifo_in"}, 32'(fifo_in), 32'd0);
        @(negedge clock); #1;
        reset = 1'b1;
    endtask

    // Invariants and scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            chk("inv_write_or_ack", 32'(write), 32'(|ack));
            chk("inv_ack_in_gnt",   32'(ack & ~gnt), 32'd0);
            chk("inv_gnt_onehot0",  32'($onehot0(gnt)), 32'd1);
            if (write) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected_write got=%0h want=none", fifo_in);
                end else begin
                    logic [DW-1:0] e;
                    e = sb.pop_front();
                    chk("sb_fifo_in", 32'(fifo_in), 32'(e));
                end
            end
        end
    end

    initial begin
        logic [3:0] oh;
        for (int i = 0; i < NREQ; i++) din_cur[i] = 16'(16'h1000 * (i + 1));
        drive_din();

        // 1: single producer, 6 words: burst of 4, one idle cycle, then 2
        do_reset("t1");
        add(4'h1, 0, 0, 4'h0, 0, 4'h0);
        repeat (4) add(4'h1, 0, 0, 4'h1, 1, 4'h1);
        add(4'h1, 0, 0, 4'h0, 0, 4'h0);
        repeat (2) add(4'h1, 0, 0, 4'h1, 1, 4'h1);
        add(4'h0, 0, 0, 4'h1, 0, 4'h0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0);
        run("t1");

        // 2: all requesting, rotation 0,1,2,3,0 with full bursts
        do_reset("t2");
        for (int b = 0; b < 5; b++) begin
            oh = 4'b0001 << (b % 4);
            add(4'hF, 0, 0, 4'h0, 0, 4'h0);
            repeat (4) add(4'hF, 0, 0, oh, 1, oh);
        end
        add(4'h0, 0, 0, 4'h0, 0, 4'h0);
        run("t2");

        // 3: producer 2 stalled by fifo_full for 3 cycles mid-burst
        do_reset("t3");
        add(4'h4, 0, 0, 4'h0, 0, 4'h0);
        repeat (2) add(4'h4, 0, 0, 4'h4, 1, 4'h4);
        repeat (3) add(4'h4, 1, 0, 4'h4, 0, 4'h0);
        repeat (2) add(4'h4, 0, 0, 4'h4, 1, 4'h4);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0);
        run("t3");

        // 4: fifo_half gives 1-word bursts; a mid-burst half does not shorten
        do_reset("t4");
        add(4'h3, 0, 1, 4'h0, 0, 4'h0);
        add(4'h3, 0, 1, 4'h1, 1, 4'h1);
        add(4'h3, 0, 1, 4'h0, 0, 4'h0);
        add(4'h3, 0, 1, 4'h2, 1, 4'h2);
        add(4'h3, 0, 1, 4'h0, 0, 4'h0);
        add(4'h3, 0, 1, 4'h1, 1, 4'h1);
        add(4'h3, 0, 0, 4'h0, 0, 4'h0);
        repeat (4) add(4'h3, 0, 1, 4'h2, 1, 4'h2);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0);
        run("t4");

        // 5: producer 1 releases early; next grant goes to 2
        do_reset("t5");
        add(4'h2, 0, 0, 4'h0, 0, 4'h0);
        repeat (2) add(4'h2, 0, 0, 4'h2, 1, 4'h2);
        add(4'hC, 0, 0, 4'h2, 0, 4'h0);
        add(4'hC, 0, 0, 4'h0, 0, 4'h0);
        add(4'hC, 0, 0, 4'h4, 1, 4'h4);
        add(4'h0, 0, 0, 4'h4, 0, 4'h0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0);
        run("t5");

        // 6: reset asserted mid-burst at cnt=2, then producer 0 wins first
        do_reset("t6");
        add(4'h4, 0, 0, 4'h0, 0, 4'h0);
        repeat (2) add(4'h4, 0, 0, 4'h4, 1, 4'h4);
        run("t6a");
        @(posedge clock); #1;
        chk("t6.midburst_gnt", 32'(gnt), 32'h4);
        reset = 1'b0;
        #1;
        chk("t6.async_gnt",     32'(gnt),     32'd0);
        chk("t6.async_write",   32'(write),   32'd0);
        chk("t6.async_ack",     32'(ack),     32'd0);
        chk("t6.async_fifo_in", 32'(fifo_in), 32'd0);
        @(posedge clock); #1;
        chk("t6.held_gnt", 32'(gnt), 32'd0);
        req = '0;
        @(negedge clock); #1;
        reset = 1'b1;
        add(4'h5, 0, 0, 4'h0, 0, 4'h0);
        add(4'h5, 0, 0, 4'h1, 1, 4'h1);
        add(4'h0, 0, 0, 4'h1, 0, 4'h0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0);
        run("t6b");

        @(negedge clock); #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
